frankencrypt_s00_axi: RTL and testbench
=======================================

FRANKENCRYPT_S00_AXI -- requirements
Module: frankencrypt_s00_axi

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width; only 32 is supported.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, AXI byte address width; word select is bits [4:2].
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-004 Ports (clock and reset first):
- S_AXI_ACLK in 1: sole clock.
- S_AXI_ARESET in 1: asynchronous reset, active-high.
- S_AXI_AWADDR in 5; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR in 5; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
- eng_start out 1: one-cycle command strobe.
- eng_op out 2: engine select (01 AES, 10 SHA, 11 RSA).
- eng_mode out 1: CMD bit0 (init/run flag).
- eng_busy in 1; eng_done in 1: engine status.
- eng_addr in 7; eng_we in 1; eng_wdata in 32: engine port into the buffer.
- eng_rdata out 32: buffer[eng_addr], registered, 1-cycle latency.

Function
REQ-005 Register map (byte offsets): 0x00 SCRATCH R/W; 0x04 CMD R/W; 0x08 PTR R/W (bits [6:0]); 0x0C DATA (buffer window); 0x10 STATUS RO (bit0 = eng_busy, bit1 = done flag); 0x14-0x1C read as 0, writes ignored.
REQ-006 The buffer SHALL be 128 x 32-bit words, held in registers or RAM, and SHALL not be cleared by reset.
REQ-007 Write channel: AWREADY and WREADY SHALL pulse high together for one cycle when AWVALID, WVALID and no pending BVALID are all present; the register update occurs on that same edge.
REQ-008 BVALID SHALL rise the cycle after the AW/W handshake, hold until BREADY is seen, and BRESP SHALL always be 00.
REQ-009 A write with only one of AWVALID or WVALID SHALL wait, asserting no ready, until both are present.
REQ-010 WSTRB SHALL byte-enable writes to SCRATCH, CMD and PTR; DATA writes SHALL require WSTRB = 1111, otherwise the word is ignored but PTR still increments.
REQ-011 Read channel: ARREADY SHALL pulse for one cycle when ARVALID is high and RVALID is low; RVALID and RDATA SHALL be valid the next cycle and held until RREADY; RRESP SHALL always be 00.
REQ-012 A DATA write SHALL store WDATA at buffer[PTR], then set PTR = PTR+1 mod 128 (127 wraps to 0).
REQ-013 A DATA read SHALL return buffer[PTR] captured at the AR handshake, then set PTR = PTR+1 mod 128 at that handshake.
REQ-014 A PTR write SHALL set the pointer to WDATA[6:0], and a read of PTR SHALL return {25'b0, PTR}.
REQ-015 A CMD write SHALL store the value, and when WDATA[31:30] != 00, it SHALL:
- assert eng_start for exactly one cycle, the cycle after the handshake;
- drive eng_op = WDATA[31:30] and eng_mode = WDATA[0], held until the next CMD write;
- clear the done flag.
REQ-016 The done flag SHALL set on any cycle with eng_done = 1 and stay set until a CMD write; an eng_done in the same cycle as a CMD write SHALL win.
REQ-017 Buffer write conflict: if eng_we and an AXI DATA write hit the same cycle, the engine write SHALL win and the AXI word SHALL be dropped, but PTR SHALL still increment.
REQ-018 AXI DATA writes while eng_busy = 1 SHALL be dropped, with PTR still incrementing; AXI reads are always served.
REQ-019 Reads and writes SHALL be independent, and a simultaneous read and write of DATA SHALL each advance PTR, for a net +2.

Reset
REQ-020 On S_AXI_ARESET high, asynchronously, the following SHALL go to 0:
- AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA;
- eng_start, eng_op, eng_mode;
- SCRATCH, CMD, PTR and the done flag.
REQ-021 A reset asserted mid-transaction SHALL abort it; after reset release, the next handshake SHALL start cleanly with no stale BVALID or RVALID.

Verification
REQ-022 Write 0x12345678 to 0x00, then read 0x00 -> RDATA 0x12345678, BRESP and RRESP 00, BVALID one cycle after AWREADY/WREADY.
REQ-023 Write PTR=0, write 96 DATA words, then read PTR -> 96 (0x60); write PTR=0, read DATA 96 times -> words returned in written order.
REQ-024 Write CMD 0xC0000001 -> eng_start single pulse, eng_op=11, eng_mode=1; write CMD 0x40000000 -> eng_op=01, eng_mode=0, eng_start pulses.
REQ-025 Pulse eng_done -> STATUS bit1 = 1; write CMD 0x80000001 -> STATUS bit1 = 0.
REQ-026 Write PTR=127, then write DATA twice -> words at buffer[127] and buffer[0], PTR = 1.
REQ-027 Engine writes buffer[44] while eng_busy = 1 and the AXI side writes DATA -> engine value kept, AXI word dropped, PTR increments; assert reset mid-write -> all outputs 0 at once.

Source files
------------

// File: rtl/frankencrypt_s00_axi.sv
// AXI4-Lite slave for the frankencrypt engine: control/status registers plus a
// 128-word shared buffer reachable through an auto-incrementing DATA window.
module frankencrypt_s00_axi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              eng_start,
  output logic [1:0]                        eng_op,
  output logic                              eng_mode,
  input  logic                              eng_busy,
  input  logic                              eng_done,
  input  logic [6:0]                        eng_addr,
  input  logic                              eng_we,
  input  logic [31:0]                       eng_wdata,
  output logic [31:0]                       eng_rdata
);

  localparam logic [2:0] REG_SCRATCH = 3'd0;
  localparam logic [2:0] REG_CMD     = 3'd1;
  localparam logic [2:0] REG_PTR     = 3'd2;
  localparam logic [2:0] REG_DATA    = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  logic        wr_ready, ar_ready, bvalid, rvalid, done;
  logic [31:0] rdata, scratch, cmd, rd_word;
  logic [6:0]  ptr, ptr_next;
  logic [31:0] buffer [0:127];

  logic       wr_fire, rd_fire, data_wr, data_rd, axi_buf_we;
  logic [2:0] wr_sel, rd_sel;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++)
      if (strb[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  assign S_AXI_AWREADY = wr_ready;
  assign S_AXI_WREADY  = wr_ready;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_BRESP   = '0;
  assign S_AXI_RRESP   = '0;

  assign wr_fire = wr_ready && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire = ar_ready && S_AXI_ARVALID;
  assign wr_sel  = S_AXI_AWADDR[4:2];
  assign rd_sel  = S_AXI_ARADDR[4:2];
  assign data_wr = wr_fire && (wr_sel == REG_DATA);
  assign data_rd = rd_fire && (rd_sel == REG_DATA);
  // Engine port has priority; busy or partial-strobe AXI words are dropped.
  assign axi_buf_we = data_wr && (S_AXI_WSTRB == '1) && !eng_busy && !eng_we;

  always_comb begin
    ptr_next = ptr + {6'b0, data_wr} + {6'b0, data_rd};
    if (wr_fire && (wr_sel == REG_PTR) && S_AXI_WSTRB[0])
      ptr_next = S_AXI_WDATA[6:0];
  end

  always_comb begin
    rd_word = '0;
    case (rd_sel)
      REG_SCRATCH: rd_word = scratch;
      REG_CMD:     rd_word = cmd;
      REG_PTR:     rd_word = {25'b0, ptr};
      REG_DATA:    rd_word = buffer[ptr];
      REG_STATUS:  rd_word = {30'b0, done, eng_busy};
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_ready  <= 1'b0;
      ar_ready  <= 1'b0;
      bvalid    <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      scratch   <= '0;
      cmd       <= '0;
      ptr       <= '0;
      done      <= 1'b0;
      eng_start <= 1'b0;
      eng_op    <= '0;
      eng_mode  <= 1'b0;
    end else begin
      wr_ready <= !wr_ready && S_AXI_AWVALID && S_AXI_WVALID && !bvalid;
      ar_ready <= !ar_ready && S_AXI_ARVALID && !rvalid;

      if (wr_fire)           bvalid <= 1'b1;
      else if (S_AXI_BREADY) bvalid <= 1'b0;

      if (rd_fire) begin
        rvalid <= 1'b1;
        rdata  <= rd_word;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end

      ptr       <= ptr_next;
      eng_start <= 1'b0;

      if (wr_fire && (wr_sel == REG_SCRATCH))
        scratch <= merge(scratch, S_AXI_WDATA, S_AXI_WSTRB);

      if (wr_fire && (wr_sel == REG_CMD)) begin
        cmd <= merge(cmd, S_AXI_WDATA, S_AXI_WSTRB);
        if (S_AXI_WDATA[31:30] != 2'b00) begin
          eng_start <= 1'b1;
          eng_op    <= S_AXI_WDATA[31:30];
          eng_mode  <= S_AXI_WDATA[0];
        end
      end

      // A done pulse coincident with a CMD write leaves the flag set.
      if (eng_done)                               done <= 1'b1;
      else if (wr_fire && (wr_sel == REG_CMD))    done <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (eng_we)          buffer[eng_addr] <= eng_wdata;
    else if (axi_buf_we) buffer[ptr]      <= S_AXI_WDATA;
    eng_rdata <= buffer[eng_addr];
  end

endmodule

// File: tb/tb_frankencrypt_s00_axi.sv
// Directed bench for frankencrypt_s00_axi: register map, buffer window, engine
// command/status handshakes, buffer arbitration and asynchronous reset.
module tb_frankencrypt_s00_axi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        eng_start, eng_mode;
  logic [1:0]  eng_op;
  logic        eng_busy = 1'b0, eng_done = 1'b0, eng_we = 1'b0;
  logic [6:0]  eng_addr = '0;
  logic [31:0] eng_wdata = '0, eng_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frankencrypt_s00_axi #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .eng_start(eng_start), .eng_op(eng_op), .eng_mode(eng_mode),
    .eng_busy(eng_busy), .eng_done(eng_done),
    .eng_addr(eng_addr), .eng_we(eng_we), .eng_wdata(eng_wdata), .eng_rdata(eng_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // b_ok: BVALID low before the handshake, high right after it, BRESP=00.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic done_at_hs, output logic b_ok,
                           output logic start_now, output logic start_next);
    logic got, pre_b;
    got = 1'b0;
    b_ok = 1'b0; start_now = 1'b0; start_next = 1'b0;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (awready && wready) begin got = 1'b1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL aw_timeout: observed=no_ready expected=ready addr=%h", addr);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    pre_b = bvalid;
    if (done_at_hs) eng_done = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; eng_done = 1'b0;
    b_ok = !pre_b && bvalid && (bresp == 2'b00);
    start_now = eng_start;
    @(posedge clk); #1;
    start_next = eng_start;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic r_ok);
    logic got;
    got = 1'b0; data = '0; r_ok = 1'b0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (arready) begin got = 1'b1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ar_timeout: observed=no_ready expected=ready addr=%h", addr);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    data = rdata;
    r_ok = rvalid && (rresp == 2'b00);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] word(input int i);
    return 32'hA500_0000 | (i * 3);
  endfunction

  initial begin
    logic        b_ok, s_now, s_next, r_ok, b2, s2, s3, r2;
    logic [31:0] d, d2;

    // reset state
    #12;
    chk("rst_awready", {31'b0, awready}, 0);
    chk("rst_bvalid",  {31'b0, bvalid}, 0);
    chk("rst_rvalid",  {31'b0, rvalid}, 0);
    chk("rst_rdata",   rdata, 0);
    chk("rst_eng",     {28'b0, eng_start, eng_op, eng_mode}, 0);
    @(negedge clk); rst = 1'b0;

    // scratch round trip and byte enables
    axi_write(5'h00, 32'h1234_5678, 4'hF, 1'b0, b_ok, s_now, s_next);
    chk("scratch_bresp", {31'b0, b_ok}, 1);
    axi_read(5'h00, d, r_ok);
    chk("scratch_rd", d, 32'h1234_5678);
    chk("scratch_rresp", {31'b0, r_ok}, 1);
    axi_write(5'h00, 32'hFFFF_FFFF, 4'h3, 1'b0, b_ok, s_now, s_next);
    axi_read(5'h00, d, r_ok);
    chk("scratch_strb", d, 32'h1234_FFFF);
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, 1'b0, b_ok, s_now, s_next);
    axi_read(5'h14, d, r_ok);
    chk("unmapped_rd", d, 0);

    // 96-word burst through the DATA window
    axi_write(5'h08, 32'h0, 4'hF, 1'b0, b_ok, s_now, s_next);
    for (int i = 0; i < 96; i++) axi_write(5'h0C, word(i), 4'hF, 1'b0, b_ok, s_now, s_next);
    axi_read(5'h08, d, r_ok);
    chk("ptr_after_96", d, 32'h60);
    axi_write(5'h08, 32'h0, 4'hF, 1'b0, b_ok, s_now, s_next);
    for (int i = 0; i < 96; i++) begin
      axi_read(5'h0C, d, r_ok);
      chk($sformatf("data_rd_%0d", i), d, word(i));
    end

    // pointer masking and wrap 127 -> 0
    axi_write(5'h08, 32'h0000_01FF, 4'hF, 1'b0, b_ok, s_now, s_next);
    axi_read(5'h08, d, r_ok);
    chk("ptr_mask", d, 32'h7F);
    axi_write(5'h0C, 32'h1111_1111, 4'hF, 1'b0, b_ok, s_now, s_next);
    axi_write(5'h0C, 32'h2222_2222, 4'hF, 1'b0, b_ok, s_now, s_next);
    axi_read(5'h08, d, r_ok);
    chk("ptr_wrap", d, 32'h1);
    axi_write(5'h08, 32'd127, 4'hF, 1'b0, b_ok, s_now, s_next);
    axi_read(5'h0C, d, r_ok);
    chk("buf127", d, 32'h1111_1111);
    axi_read(5'h0C, d, r_ok);
    chk("buf0", d, 32'h2222_2222);

    // partial-strobe DATA write dropped, pointer still advances
    axi_write(5'h08, 32'd5, 4'hF, 1'b0, b_ok, s_now, s_next);
    axi_write(5'h0C, 32'h0000_DEAD, 4'h7, 1'b0, b_ok, s_now, s_next);
    axi_read(5'h08, d, r_ok);
    chk("ptr_partial", d, 32'd6);
    axi_write(5'h08, 32'd5, 4'hF, 1'b0, b_ok, s_now, s_next);
    axi_read(5'h0C, d, r_ok);
    chk("buf_partial", d, word(5));

    // engine commands
    axi_write(5'h04, 32'hC000_0001, 4'hF, 1'b0, b_ok, s_now, s_next);
    chk("cmd1_start", {30'b0, s_now, s_next}, 32'b10);
    chk("cmd1_op_mode", {29'b0, eng_op, eng_mode}, 32'b111);
    axi_read(5'h04, d, r_ok);
    chk("cmd_rd", d, 32'hC000_0001);
    axi_write(5'h04, 32'h4000_0000, 4'hF, 1'b0, b_ok, s_now, s_next);
    chk("cmd2_start", {30'b0, s_now, s_next}, 32'b10);
    chk("cmd2_op_mode", {29'b0, eng_op, eng_mode}, 32'b010);
    axi_write(5'h04, 32'h0000_0005, 4'hF, 1'b0, b_ok, s_now, s_next);
    chk("cmd_nop_start", {31'b0, s_now}, 0);

    // done flag set/clear and STATUS busy bit
    @(negedge clk); eng_done = 1'b1;
    @(negedge clk); eng_done = 1'b0;
    axi_read(5'h10, d, r_ok);
    chk("status_done", d, 32'h2);
    eng_busy = 1'b1;
    axi_read(5'h10, d, r_ok);
    chk("status_busy", d, 32'h3);
    eng_busy = 1'b0;
    axi_write(5'h04, 32'h8000_0001, 4'hF, 1'b0, b_ok, s_now, s_next);
    axi_read(5'h10, d, r_ok);
    chk("status_clr", d, 32'h0);
    chk("cmd3_op_mode", {29'b0, eng_op, eng_mode}, 32'b101);
    axi_write(5'h04, 32'h8000_0001, 4'hF, 1'b1, b_ok, s_now, s_next);
    axi_read(5'h10, d, r_ok);
    chk("done_wins", d, 32'h2);
    axi_write(5'h04, 32'h8000_0001, 4'hF, 1'b0, b_ok, s_now, s_next);

    // busy drops AXI word
    axi_write(5'h08, 32'd10, 4'hF, 1'b0, b_ok, s_now, s_next);
    eng_busy = 1'b1;
    axi_write(5'h0C, 32'hBADB_AD00, 4'hF, 1'b0, b_ok, s_now, s_next);
    eng_busy = 1'b0;
    axi_read(5'h08, d, r_ok);
    chk("ptr_busy", d, 32'd11);
    axi_write(5'h08, 32'd10, 4'hF, 1'b0, b_ok, s_now, s_next);
    axi_read(5'h0C, d, r_ok);
    chk("buf_busy", d, word(10));

    // engine write beats AXI write to buffer[44]
    axi_write(5'h08, 32'd44, 4'hF, 1'b0, b_ok, s_now, s_next);
    eng_addr = 7'd44; eng_wdata = 32'h0E0E_0E0E; eng_we = 1'b1;
    axi_write(5'h0C, 32'h5A5A_5A5A, 4'hF, 1'b0, b_ok, s_now, s_next);
    eng_we = 1'b0;
    axi_read(5'h08, d, r_ok);
    chk("ptr_conflict", d, 32'd45);
    axi_write(5'h08, 32'd44, 4'hF, 1'b0, b_ok, s_now, s_next);
    axi_read(5'h0C, d, r_ok);
    chk("buf_conflict", d, 32'h0E0E_0E0E);
    @(negedge clk); eng_addr = 7'd45;
    @(negedge clk);
    chk("eng_rdata45", eng_rdata, word(45));
    eng_addr = 7'd0;
    @(negedge clk);
    chk("eng_rdata0", eng_rdata, 32'h2222_2222);

    // simultaneous DATA read and write: net +2
    axi_write(5'h08, 32'd20, 4'hF, 1'b0, b_ok, s_now, s_next);
    fork
      axi_write(5'h0C, 32'h7777_7777, 4'hF, 1'b0, b2, s2, s3);
      axi_read(5'h0C, d2, r2);
    join
    axi_read(5'h08, d, r_ok);
    chk("ptr_rw", d, 32'd22);

    // reset mid-write
    @(negedge clk); eng_done = 1'b1;
    @(negedge clk); eng_done = 1'b0;
    awaddr = 5'h00; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("pre_rst_ready", {31'b0, awready}, 1);
    rst = 1'b1; #1;
    chk("mid_rst_ready", {30'b0, awready, wready}, 0);
    chk("mid_rst_valid", {30'b0, bvalid, rvalid}, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_eng", {28'b0, eng_start, eng_op, eng_mode}, 0);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk); rst = 1'b0;
    axi_read(5'h00, d, r_ok);
    chk("post_scratch", d, 0);
    axi_read(5'h04, d, r_ok);
    chk("post_cmd", d, 0);
    axi_read(5'h10, d, r_ok);
    chk("post_status", d, 0);
    axi_read(5'h08, d, r_ok);
    chk("post_ptr", d, 0);
    axi_read(5'h0C, d, r_ok);
    chk("post_buf0", d, 32'h2222_2222);
    axi_write(5'h00, 32'h0BAD_CAFE, 4'hF, 1'b0, b_ok, s_now, s_next);
    chk("post_bresp", {31'b0, b_ok}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
